phase_accum_loader: RTL



---
 rtl/phase_accum_pkg.sv | 12 +
 rtl/phase_accum_loader_frame_timeout.sv | 18 +
 rtl/phase_accum_loader.sv | 79 +++++++
 3 files changed

// File: rtl/phase_accum_pkg.sv
// phase_accum_pkg: shared command codes, sync marker and loader state type
package phase_accum_pkg;
  localparam logic [7:0] CMD_WR_DIVF = 8'h01;
  localparam logic [7:0] CMD_WR_DIVR = 8'h02;
  localparam logic [7:0] CMD_EN_OFF = 8'h10;
  localparam logic [7:0] CMD_EN_ON = 8'h11;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, CHECK, ISSUE} state_t;
  function automatic logic cmd_ok(input logic [7:0] c);
    return c inside {CMD_WR_DIVF, CMD_WR_DIVR, CMD_EN_OFF, CMD_EN_ON};
  endfunction
endpackage

// File: rtl/phase_accum_loader_frame_timeout.sv
// frame_timeout: inter-byte idle counter, expired when it sits at TIMEOUT-1
module frame_timeout #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/phase_accum_loader.sv
// phase_accum_loader: frames host bytes into tuning-word writes and enable changes
module phase_accum_loader
  import phase_accum_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int TIMEOUT = 1000,
  parameter int TO_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] data,
  output logic       wr_divf,
  output logic       wr_divr,
  output logic       en,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);
  state_t state, next;
  logic [7:0] cmd, payload;
  logic accept, in_frame, expired, timed_out, issue_go, bad_chk, err;
  assign rx_ready = state != ISSUE;
  assign busy = state != IDLE;
  assign accept = rx_valid && rx_ready;
  assign in_frame = state inside {CMD, PAYLOAD, CHECK};
  assign timed_out = in_frame && !accept && expired;
  assign err = bad_chk || timed_out;
  frame_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(accept || timed_out || !in_frame),
    .en(in_frame),
    .expired(expired)
  );
  always_comb begin
    next = state;
    issue_go = 1'b0;
    bad_chk = 1'b0;
    case (state)
      IDLE: next = accept && rx_data == SYNC_BYTE ? CMD : IDLE;
      CMD: next = accept ? PAYLOAD : CMD;
      PAYLOAD: next = accept ? CHECK : PAYLOAD;
      CHECK: begin
        issue_go = accept && (cmd ^ payload) == rx_data && cmd_ok(cmd);
        bad_chk = accept && !issue_go;
        next = issue_go ? ISSUE : bad_chk ? IDLE : CHECK;
      end
      default: next = IDLE;
    endcase
    if (timed_out) next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd <= '0;
      payload <= '0;
      data <= '0;
      wr_divf <= 1'b0;
      wr_divr <= 1'b0;
      en <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (state == CMD && accept) cmd <= rx_data;
      if (state == PAYLOAD && accept) payload <= rx_data;
      if (issue_go) data <= payload;
      wr_divf <= issue_go && cmd == CMD_WR_DIVF;
      wr_divr <= issue_go && cmd == CMD_WR_DIVR;
      if (issue_go && cmd == CMD_EN_ON) en <= 1'b1;
      else if (issue_go && cmd == CMD_EN_OFF) en <= 1'b0;
      frame_err <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule
